mem_arbiter: RTL and testbench

Two-master arbiter sharing the single `memory` block between two picorv32-style native-bus requesters: m0, the CPU, and m1, a second CPU or a DMA/debug master. It sits between the masters and `memory`. It grants one transaction at a time, with round-robin priority and grant held until completion. A watchdog terminates transactions the target never acknowledges.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single native-bus memory.
// One transaction is in flight at a time. Grant is held until the memory
// acknowledges or the watchdog expires, and each completion is followed by
// one IDLE cycle.
module mem_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // A zero TIMEOUT still needs a legal (unused) one-bit counter.
  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int            TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state, state_next;
  logic          last, last_next;     // master that completed most recently
  logic [CW-1:0] count, count_next;   // cycles spent waiting in the current grant
  logic          wd_fire;

  // State, priority pointer and watchdog counter.
  // last resets to 1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state <= IDLE;
      last  <= 1'b1;
      count <= '0;
    end else begin
      state <= state_next;
      last  <= last_next;
      count <= count_next;
    end
  end

  // The watchdog fires on the last allowed grant cycle, unless the memory answers in that same cycle.
  assign wd_fire = (TIMEOUT != 0) && (count == TLIM_C) && !mem_ready;

  // Next-state logic, bus forwarding and completion signalling.
  always_comb begin
    state_next  = state;
    last_next   = last;
    count_next  = count;
    mem_valid   = 1'b0;
    mem_instr   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    grant       = 2'b00;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        if (m0_valid && (!m1_valid || last)) state_next = GNT0;
        else if (m1_valid)                   state_next = GNT1;
      end
      GNT0: begin
        mem_valid = 1'b1;
        mem_instr = m0_instr;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
        grant     = 2'b01;
        if (mem_ready) begin
          m0_ready   = 1'b1;
          m0_rdata   = mem_rdata;
          state_next = IDLE;
          last_next  = 1'b0;
        end else if (wd_fire) begin
          m0_ready    = 1'b1;
          m0_rdata    = ERR_DATA;
          timeout_err = 1'b1;
          state_next  = IDLE;
          last_next   = 1'b0;
        end else begin
          count_next = count + CW'(1);
        end
      end
      GNT1: begin
        mem_valid = 1'b1;
        mem_instr = m1_instr;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
        grant     = 2'b10;
        if (mem_ready) begin
          m1_ready   = 1'b1;
          m1_rdata   = mem_rdata;
          state_next = IDLE;
          last_next  = 1'b1;
        end else if (wd_fire) begin
          m1_ready    = 1'b1;
          m1_rdata    = ERR_DATA;
          timeout_err = 1'b1;
          state_next  = IDLE;
          last_next   = 1'b1;
        end else begin
          count_next = count + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT = 8) with a latency-programmable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  // Memory model state: the response comes on grant cycle lat; address 0x9000 never answers.
  int          lat = 2;
  int          wait_cnt = 0;
  logic [31:0] store [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .resn(resn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  // Memory responder. It updates 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [31:0] word;
    #1;
    if (!resn || !mem_valid) begin
      wait_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
    end else begin
      wait_cnt++;
      if (wait_cnt == lat && mem_addr != 32'h9000) begin
        mem_ready = 1'b1;
        word = store.exists(mem_addr) ? store[mem_addr] : 32'h0;
        if (mem_wstrb == 4'b0000) begin
          mem_rdata = word;
        end else begin
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
          store[mem_addr] = word;
          mem_rdata = '0;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Waits on falling edges until the selected ready is seen (0: m0, 1: m1, 2: either).
  task automatic run_until_ready(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && m0_ready) || (which == 1 && m1_ready) ||
          (which == 2 && (m0_ready || m1_ready))) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    resn = 1'b0;
    m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h55; m0_wdata = 32'h77; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0;    m1_wdata = '0;     m1_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", m1_ready, m0_ready); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_rdata, m1_rdata); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0b exp=0", timeout_err); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wstrb); end
    m0_valid = 1'b0;
    resn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    lat = 2;
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    #1;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL read_mem_valid_early got=%0b exp=0", mem_valid); end
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL read_granted got=%0b/%b exp=1/01", mem_valid, grant); end
    checks++; if (mem_addr !== 32'h100 || mem_instr !== 1'b1) begin failures++; $display("FAIL read_fwd got=%h/%0b exp=00000100/1", mem_addr, mem_instr); end
    checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL read_ready_early got=%0b exp=0", m0_ready); end
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678) begin failures++; $display("FAIL read_done got=%0b/%h exp=1/12345678", m0_ready, m0_rdata); end
    checks++; if (grant !== 2'b01 || m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL read_other got=%b/%0b/%h exp=01/0/0", grant, m1_ready, m1_rdata); end
    $display("txn m0 read 0x100 -> %h", m0_rdata);
    m0_valid = 1'b0; m0_instr = 1'b0;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b0 || grant !== 2'b00 || mem_valid !== 1'b0) begin failures++; $display("FAIL read_idle got=%0b/%b/%0b exp=0/00/0", m0_ready, grant, mem_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] seq [4];
    logic [1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prev = 2'b00;
    int n = 0;
    int both = 0;
    bit ok;
    resn = 1'b0;
    @(negedge clk);
    resn = 1'b1;
    lat = 2;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h104; m1_wstrb = 4'h0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (grant == 2'b11) both++;
      if (grant != 2'b00 && prev == 2'b00) begin seq[n] = grant; n++; end
      if (m0_ready || m1_ready) $display("txn contention grant=%b rdata=%h", grant, m0_ready ? m0_rdata : m1_rdata);
      prev = grant;
    end
    run_until_ready(2, 10, ok);
    m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    checks++; if (n !== 4 || !ok) begin failures++; $display("FAIL contention_count got=%0d/%0b exp=4/1", n, ok); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== exp_seq[i]) begin failures++; $display("FAIL contention_seq%0d got=%b exp=%b", i, seq[i], exp_seq[i]); end
    end
    checks++; if (both !== 0) begin failures++; $display("FAIL contention_both_bits got=%0d exp=0", both); end
  endtask

  task automatic test_write_fwd();
    int gc = 0;
    bit done = 1'b0;
    bit ok;
    lat = 3;
    m1_valid = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'b0011;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (grant == 2'b10) begin
        gc++;
        checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'hCAFEF00D || mem_wstrb !== 4'b0011) begin failures++; $display("FAIL write_fwd_c%0d got=%h/%h/%b exp=00000040/cafef00d/0011", gc, mem_addr, mem_wdata, mem_wstrb); end
      end
      if (m1_ready) done = 1'b1;
    end
    checks++; if (!done || gc !== 3) begin failures++; $display("FAIL write_done got=%0b/%0d exp=1/3", done, gc); end
    $display("txn m1 write 0x40 <- cafef00d strb 0011");
    m1_valid = 1'b0; m1_wstrb = 4'h0; m1_wdata = '0;
    @(negedge clk);
    lat = 2;
    m0_valid = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h0;
    run_until_ready(0, 10, ok);
    checks++; if (!ok || m0_rdata !== 32'h0000F00D) begin failures++; $display("FAIL write_readback got=%0b/%h exp=1/0000f00d", ok, m0_rdata); end
    $display("txn m0 read 0x40 -> %h", m0_rdata);
    m0_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int gc = 0;
    bit done = 1'b0;
    bit ok;
    lat = 2;
    m0_valid = 1'b1; m0_addr = 32'h9000; m0_wstrb = 4'h0;
    for (int c = 0; c < 14 && !done; c++) begin
      @(negedge clk);
      if (grant == 2'b01) begin
        gc++;
        if (gc == 1) begin m1_valid = 1'b1; m1_addr = 32'h104; m1_wstrb = 4'h0; end
        if (gc < 8) begin
          checks++; if (m0_ready !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early_c%0d got=%0b/%0b exp=0/0", gc, m0_ready, timeout_err); end
        end else begin
          checks++; if (m0_ready !== 1'b1 || timeout_err !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL timeout_fire got=%0b/%0b/%h exp=1/1/deadbeef", m0_ready, timeout_err, m0_rdata); end
          checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL timeout_other_ready got=%0b exp=0", m1_ready); end
          $display("txn m0 read 0x9000 timed out -> %h", m0_rdata);
          m0_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL timeout_never got=%0d exp=8", gc); end
    @(negedge clk);
    checks++; if (grant !== 2'b00 || mem_valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_idle got=%b/%0b/%0b exp=00/0/0", grant, mem_valid, timeout_err); end
    @(negedge clk);
    checks++; if (grant !== 2'b10 || mem_addr !== 32'h104) begin failures++; $display("FAIL timeout_next_grant got=%b/%h exp=10/00000104", grant, mem_addr); end
    run_until_ready(1, 10, ok);
    checks++; if (!ok || m1_rdata !== 32'hA5A50104) begin failures++; $display("FAIL timeout_m1_read got=%0b/%h exp=1/a5a50104", ok, m1_rdata); end
    $display("txn m1 read 0x104 -> %h", m1_rdata);
    m1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int gc = 0;
    bit done = 1'b0;
    lat = 8;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    for (int c = 0; c < 14 && !done; c++) begin
      @(negedge clk);
      if (grant == 2'b01) begin
        gc++;
        if (gc < 8) begin
          checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL boundary_early_c%0d got=%0b exp=0", gc, m0_ready); end
        end else begin
          checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h12345678 || timeout_err !== 1'b0) begin failures++; $display("FAIL boundary_done got=%0b/%h/%0b exp=1/12345678/0", m0_ready, m0_rdata, timeout_err); end
          $display("txn m0 read 0x100 (late ack) -> %h", m0_rdata);
          m0_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
    checks++; if (!done) begin failures++; $display("FAIL boundary_never got=%0d exp=8", gc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat = 5;
    m1_valid = 1'b1; m1_addr = 32'h104; m1_wstrb = 4'h0;
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin failures++; $display("FAIL resetmid_granted got=%b exp=10", grant); end
    #2 resn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || grant !== 2'b00 || m1_ready !== 1'b0) begin failures++; $display("FAIL resetmid_abort got=%0b/%b/%0b exp=0/00/0", mem_valid, grant, m1_ready); end
    lat = 2;
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    @(negedge clk);
    resn = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL resetmid_first got=%b exp=01", grant); end
    run_until_ready(0, 10, ok);
    checks++; if (!ok || m0_rdata !== 32'h12345678) begin failures++; $display("FAIL resetmid_m0 got=%0b/%h exp=1/12345678", ok, m0_rdata); end
    $display("txn m0 read 0x100 after reset -> %h", m0_rdata);
    m0_valid = 1'b0;
    run_until_ready(1, 10, ok);
    checks++; if (!ok || m1_rdata !== 32'hA5A50104) begin failures++; $display("FAIL resetmid_m1 got=%0b/%h exp=1/a5a50104", ok, m1_rdata); end
    $display("txn m1 read 0x104 after reset -> %h", m1_rdata);
    m1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    store[32'h100] = 32'h12345678;
    store[32'h104] = 32'hA5A50104;
    store[32'h40]  = 32'h0000AAAA;
    test_reset();
    test_single_read();
    test_contention();
    test_write_fwd();
    test_timeout();
    test_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
